gray_code_counter: RTL
======================

Name: gray_code_counter

Overview:
- Parametrised, registered Gray-code counter. Successor to the combinational 4-bit binary-to-Gray encoder.
- Holds a binary state internally. Counts up or down, supports a parallel load of a Gray-coded value, and either wraps or saturates at the ends.
- Drives glitch-free registered Gray and binary outputs. Used for clock-domain-safe pointers and position encoders in the lab designs.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.
- WRAP, 1, 1 = modular wrap-around at the ends; 0 = saturate at 0 and at 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per clk while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- Dgray  input  WIDTH  Gray-coded load value.
- Ngray  output  WIDTH  registered Gray code of the current count.
- Nbin  output  WIDTH  registered binary value of the current count.
- tc  output  1  terminal count, combinational from the state.
- wrap  output  1  one-cycle pulse, registered.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, and clears Nbin, Ngray and wrap to 0 immediately, independent of clk. Release takes effect on the next rising edge.
- Priority per rising edge: reset > load > en > hold.
- load=1:
  - Nbin <= gray-to-binary of Dgray: bin[WIDTH-1] = g[WIDTH-1], then bin[i] = bin[i+1] ^ g[i].
  - Ngray <= Dgray.
  - en and up are ignored that cycle. wrap <= 0.
- en=1, load=0, up=1:
  - Nbin < MAX (2^WIDTH-1): Nbin <= Nbin+1.
  - Nbin == MAX, WRAP=1: Nbin <= 0, wrap <= 1.
  - Nbin == MAX, WRAP=0: hold, wrap <= 0.
- en=1, load=0, up=0:
  - Nbin > 0: Nbin <= Nbin-1.
  - Nbin == 0, WRAP=1: Nbin <= MAX, wrap <= 1.
  - Nbin == 0, WRAP=0: hold, wrap <= 0.
- en=0, load=0: hold all state, wrap <= 0.
- Ngray encoding:
  - Ngray is always the registered value next_bin ^ (next_bin >> 1). It is computed from the next binary value, not decoded from Nbin after the edge.
  - Ngray and Nbin update on the same edge.
  - Consecutive count steps change exactly one Ngray bit; a load may change any number of bits.
- Latency: one cycle from a sampled en or load to the updated outputs.
- tc = (up & Nbin==MAX) | (~up & Nbin==0). It reacts combinationally to up and is independent of en.
- wrap is high for exactly one cycle, following the edge that wrapped. It is never asserted when WRAP=0.
- Direction change takes effect on the same edge it is sampled; there is no turnaround cycle.
- Reset mid-operation: outputs go to 0 asynchronously, and any pending load or count is discarded.
- Load of MAX or 0 followed by en in the ends-direction behaves per the wrap/saturate rules above.

Test Plan:
- Reset, then WIDTH=4, en=1, up=1 for 16 cycles -> Ngray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000. Nbin goes 0..15. Exactly one Ngray bit toggles per step.
- WRAP=1 at Nbin=15, up=1, en=1 for one cycle -> Nbin=0, Ngray=0000, wrap=1 for one cycle then 0. tc=1 before the edge.
- From reset, up=0, en=1 for one cycle -> Nbin=15, Ngray=1000, wrap=1. Then Nbin=14 and Ngray=1001 on the next cycle.
- load=1, Dgray=1101 with en=1 and up=1 in the same cycle -> Nbin=1001 (9), Ngray=1101, wrap=0. The load wins and no increment occurs.
- WRAP=0, count up to 15 and hold en=1 for 3 more cycles -> Nbin stays 15, Ngray stays 1000, wrap never asserted, tc=1. Switching to up=0 makes tc=0 and the next edge gives Nbin=14.
- Assert reset asynchronously mid-cycle at Nbin=6 -> Nbin, Ngray and wrap go to 0 before the next edge. After release, counting resumes from 0.

Source files
------------

// File: rtl/gray_code_counter.sv
// rtl/gray_code_counter.sv - registered up/down Gray-code counter with load, wrap or saturate
//
// Keeps the count in binary internally and registers both the binary value
// and its Gray encoding on the same edge, so Ngray never glitches.
//
// Parameters:
//   WIDTH  counter width in bits (2..16)
//   WRAP   1 = modular wrap at the ends, 0 = saturate at 0 and 2^WIDTH-1
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset; clears Nbin, Ngray, wrap
//   en     in   count enable, one step per clock while high
//   up     in   direction: 1 = increment, 0 = decrement
//   load   in   synchronous parallel load of Dgray (beats en)
//   Dgray  in   Gray-coded load value
//   Ngray  out  registered Gray code of the count
//   Nbin   out  registered binary count
//   tc     out  terminal count in the current direction (combinational)
//   wrap   out  one-cycle pulse after an edge that wrapped

module gray_code_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] Dgray,
    output logic [WIDTH-1:0] Ngray,
    output logic [WIDTH-1:0] Nbin,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] next_bin;
    logic             next_wrap;

    assign at_max  = (Nbin == MAX);
    assign at_zero = (Nbin == ZERO);

    // tc follows up directly so a direction change shows immediately.
    assign tc = (up & at_max) | (~up & at_zero);

    always_comb begin
        next_bin  = Nbin;
        next_wrap = 1'b0;
        if (load) begin
            next_bin = gray2bin(Dgray);
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    next_bin = Nbin + ONE;
                end else if (WRAP) begin
                    next_bin  = ZERO;
                    next_wrap = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    next_bin = Nbin - ONE;
                end else if (WRAP) begin
                    next_bin  = MAX;
                    next_wrap = 1'b1;
                end
            end
        end
    end

    // Ngray is encoded from next_bin before the edge so both outputs are
    // plain flops with no decode logic behind them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Nbin  <= '0;
            Ngray <= '0;
            wrap  <= 1'b0;
        end else begin
            Nbin  <= next_bin;
            Ngray <= next_bin ^ (next_bin >> 1);
            wrap  <= next_wrap;
        end
    end

endmodule
